// File: rtl/melody_sequencer.sv
// Keypad-driven two-song melody player: synchronizes key levels, steps a note ROM
// at a programmable tempo and emits a registered tone divider for the note generator.
module melody_sequencer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int SONG_LEN = 32,
  parameter int LOOP     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keycode,
  output logic [19:0] note_div,
  output logic [1:0]  state,
  output logic [4:0]  beat_idx,
  output logic        song_sel,
  output logic [3:0]  beat_len
);

  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_PLAY = 2'd1, ST_PAUSE = 2'd2} st_e;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  st_e           state_q, state_nxt;
  logic [4:0]    sync1, sync2, key_prev, key_edge;
  logic [TW-1:0] tick_ctr;
  logic [3:0]    beat_ctr;
  logic          k_play, k_stop, k_next, k_up, k_dn;
  logic          tick_wrap, beat_end, song_end;
  logic [3:0]    rom_idx;
  logic [19:0]   note_val;
  logic          unused_keys;

  assign unused_keys = ^keycode[15:5];

  // Keys come from another clock domain; edge pulse is registered after the 2-flop sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      key_prev <= '0;
      key_edge <= '0;
    end else begin
      sync1    <= keycode[4:0];
      sync2    <= sync1;
      key_prev <= sync2;
      key_edge <= sync2 & ~key_prev;
    end
  end

  assign k_play = key_edge[0];
  assign k_stop = key_edge[1];
  assign k_next = key_edge[2];
  assign k_up   = key_edge[3];
  assign k_dn   = key_edge[4];

  assign tick_wrap = (tick_ctr == TW'(TICK_DIV - 1));
  // >= so a beat_len shortened mid-beat ends the beat at the next tick wrap
  assign beat_end  = tick_wrap && (beat_ctr >= beat_len - 4'd1);
  assign song_end  = beat_end && (beat_idx == 5'(SONG_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STOP;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (k_stop)
      state_nxt = ST_STOP;
    else if (k_next)
      state_nxt = state_q;
    else if (state_q == ST_PLAY && song_end && LOOP == 0)
      state_nxt = ST_STOP;
    else if (k_play) begin
      case (state_q)
        ST_STOP:  state_nxt = ST_PLAY;
        ST_PLAY:  state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_PLAY;
        default:  state_nxt = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ctr <= '0;
      beat_ctr <= '0;
      beat_idx <= '0;
    end else if (k_stop || k_next || state_q == ST_STOP) begin
      tick_ctr <= '0;
      beat_ctr <= '0;
      beat_idx <= '0;
    end else if (state_q == ST_PLAY) begin
      if (beat_end) begin
        tick_ctr <= '0;
        beat_ctr <= '0;
        beat_idx <= song_end ? 5'd0 : beat_idx + 5'd1;
      end else if (tick_wrap) begin
        tick_ctr <= '0;
        beat_ctr <= beat_ctr + 4'd1;
      end else begin
        tick_ctr <= tick_ctr + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_sel <= 1'b0;
      beat_len <= 4'd8;
    end else begin
      if (k_next) song_sel <= ~song_sel;
      if (k_up && !k_dn && beat_len > 4'd2)
        beat_len <= beat_len - 4'd1;
      else if (k_dn && !k_up && beat_len < 4'd15)
        beat_len <= beat_len + 4'd1;
    end
  end

  assign rom_idx = song_sel ? (4'd8 - {1'b0, beat_idx[2:0]})
                            : ({1'b0, beat_idx[2:0]} + 4'd1);

  always_comb begin
    note_val = 20'd0;
    case (rom_idx)
      4'd1: note_val = 20'd382219;
      4'd2: note_val = 20'd340530;
      4'd3: note_val = 20'd303370;
      4'd4: note_val = 20'd286344;
      4'd5: note_val = 20'd255102;
      4'd6: note_val = 20'd227272;
      4'd7: note_val = 20'd202478;
      4'd8: note_val = 20'd191113;
      default: note_val = 20'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) note_div <= '0;
    else        note_div <= (state_q == ST_PLAY) ? note_val : 20'd0;
  end

  assign state = state_q;

endmodule
